key_scan: RTL and testbench



---
 rtl/key_scan.sv | 157 +++++++++++++++
 tb/tb_key_scan.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_scan.sv
`default_nettype none
// ============================================================================
// Module   : key_scan
// Purpose  : 3x3 pad matrix scanner plus four direct left buttons, each
//            synchronized, debounced and reported as a level and press pulse.
// Revision : 1.0
// ============================================================================
module key_scan #(
    parameter int SCAN_DIV     = 12000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic       CLK,
    input  logic       RESET_N,
    output logic [2:0] COL_OUT,
    input  logic [2:0] ROW_IN,
    input  logic [3:0] LEFT_BTN_N,
    output logic [8:0] KEY,
    output logic [8:0] KEY_PRESS,
    output logic [3:0] LEFT_KEY,
    output logic [3:0] LEFT_PRESS
);

    localparam int                DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int                CNT_W    = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
    localparam int                NKEY     = 13;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2
    } col_e;

    logic [2:0]       row_s1_q, row_s2_q;
    logic [3:0]       left_s1_q, left_s2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    col_e             col_q;
    logic [2:0]       col_out_q;
    logic [2:0]       col_sel;
    logic [NKEY-1:0]  raw;
    logic [NKEY-1:0]  samp;
    logic [NKEY-1:0]  key_vec;
    logic [NKEY-1:0]  press_vec;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            row_s1_q  <= '1;
            row_s2_q  <= '1;
            left_s1_q <= '1;
            left_s2_q <= '1;
        end else begin
            row_s1_q  <= ROW_IN;
            row_s2_q  <= row_s1_q;
            left_s1_q <= LEFT_BTN_N;
            left_s2_q <= left_s1_q;
        end
    end

    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? '0 : div_q + DIV_W'(1);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            col_q     <= COL0;
            col_out_q <= 3'b110;
        end else if (tick) begin
            case (col_q)
                COL0: begin
                    col_q     <= COL1;
                    col_out_q <= 3'b101;
                end
                COL1: begin
                    col_q     <= COL2;
                    col_out_q <= 3'b011;
                end
                default: begin
                    col_q     <= COL0;
                    col_out_q <= 3'b110;
                end
            endcase
        end
    end

    assign col_sel = {col_q == COL2, col_q == COL1, col_q == COL0};

    // Pads are sampled at the end of their column's drive window, just before it advances.
    always_comb begin
        raw  = '0;
        samp = '0;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
                raw[c*3+r]  = ~row_s2_q[r];
                samp[c*3+r] = tick & col_sel[c];
            end
        end
        raw[12:9]  = ~left_s2_q;
        samp[12:9] = {4{tick}};
    end

    generate
        for (genvar i = 0; i < NKEY; i++) begin : g_deb
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             stable_q, stable_d;
            logic             press_q, press_d;

            always_comb begin
                cnt_d    = cnt_q;
                stable_d = stable_q;
                press_d  = 1'b0;
                if (samp[i]) begin
                    if (raw[i] == stable_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d    = '0;
                        stable_d = raw[i];
                        press_d  = raw[i];
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                    press_q  <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                    press_q  <= press_d;
                end
            end

            assign key_vec[i]   = stable_q;
            assign press_vec[i] = press_q;
        end
    endgenerate

    assign COL_OUT    = col_out_q;
    assign KEY        = key_vec[8:0];
    assign KEY_PRESS  = press_vec[8:0];
    assign LEFT_KEY   = key_vec[12:9];
    assign LEFT_PRESS = press_vec[12:9];

endmodule
`default_nettype wire

// File: tb/tb_key_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_scan
// Purpose  : Self-checking bench for key_scan with a simple diode-matrix board.
// Revision : 1.0
// ============================================================================
module tb_key_scan;

    localparam int SD = 4;
    localparam int DC = 3;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [2:0] COL_OUT;
    logic [2:0] ROW_IN;
    logic [3:0] LEFT_BTN_N = 4'hF;
    logic [8:0] KEY;
    logic [8:0] KEY_PRESS;
    logic [3:0] LEFT_KEY;
    logic [3:0] LEFT_PRESS;

    logic [8:0] pads = '0;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [8:0] kp_seen = '0;
    int         kp_total = 0;
    logic [3:0] lp_seen = '0;
    int         lp_total = 0;

    typedef struct {
        logic [3:0] left_n;
        logic [8:0] pads;
        int         ticks;
        logic [8:0] key;
        logic [3:0] lkey;
        logic [8:0] kpm;
        int         kpn;
        logic [3:0] lpm;
        int         lpn;
    } vec_t;

    vec_t vecs [10];

    key_scan #(
        .SCAN_DIV     (SD),
        .DEBOUNCE_CNT (DC)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .COL_OUT    (COL_OUT),
        .ROW_IN     (ROW_IN),
        .LEFT_BTN_N (LEFT_BTN_N),
        .KEY        (KEY),
        .KEY_PRESS  (KEY_PRESS),
        .LEFT_KEY   (LEFT_KEY),
        .LEFT_PRESS (LEFT_PRESS)
    );

    always #5 CLK = ~CLK;

    // A pressed pad pulls its row low whenever its column is driven low.
    always_comb begin
        ROW_IN = 3'b111;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
                if (!COL_OUT[c] && pads[c*3+r]) ROW_IN[r] = 1'b0;
            end
        end
    end

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    always @(negedge CLK) begin
        kp_seen  = kp_seen | KEY_PRESS;
        kp_total = kp_total + $countones(KEY_PRESS);
        lp_seen  = lp_seen | LEFT_PRESS;
        lp_total = lp_total + $countones(LEFT_PRESS);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        kp_seen  = '0;
        kp_total = 0;
        lp_seen  = '0;
        lp_total = 0;
    endtask

    // Returns 1 ns after the n-th following scan-tick edge.
    task automatic wait_tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
            while (cyc % SD != 0) begin
                @(posedge CLK);
                #1;
            end
        end
    endtask

    initial begin
        logic [2:0] colpat [3];
        int         bad;

        colpat[0] = 3'b110;
        colpat[1] = 3'b101;
        colpat[2] = 3'b011;

        vecs[0] = '{4'hF, 9'h020, 6, 9'h000, 4'h0, 9'h000, 0, 4'h0, 0};
        vecs[1] = '{4'hF, 9'h020, 3, 9'h020, 4'h0, 9'h020, 1, 4'h0, 0};
        vecs[2] = '{4'h7, 9'h121, 2, 9'h020, 4'h0, 9'h000, 0, 4'h0, 0};
        vecs[3] = '{4'h7, 9'h121, 1, 9'h020, 4'h8, 9'h000, 0, 4'h8, 1};
        vecs[4] = '{4'h7, 9'h121, 6, 9'h121, 4'h8, 9'h101, 2, 4'h0, 0};
        vecs[5] = '{4'hF, 9'h000, 2, 9'h121, 4'h8, 9'h000, 0, 4'h0, 0};
        vecs[6] = '{4'hF, 9'h000, 7, 9'h000, 4'h0, 9'h000, 0, 4'h0, 0};
        vecs[7] = '{4'h0, 9'h1FF, 9, 9'h1FF, 4'hF, 9'h1FF, 9, 4'hF, 4};
        vecs[8] = '{4'hA, 9'h0AA, 9, 9'h0AA, 4'h5, 9'h000, 0, 4'h0, 0};
        vecs[9] = '{4'hF, 9'h000, 9, 9'h000, 4'h0, 9'h000, 0, 4'h0, 0};

        // Reset state and idle scanning
        #23;
        chk("rst_col", COL_OUT, 3'b110);
        chk("rst_key", KEY, 9'h000);
        chk("rst_kpress", KEY_PRESS, 9'h000);
        chk("rst_lkey", LEFT_KEY, 4'h0);
        chk("rst_lpress", LEFT_PRESS, 4'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        bad = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge CLK);
            #1;
            if (k <= 12) chk("col_seq", COL_OUT, colpat[(k / SD) % 3]);
            if ((KEY | KEY_PRESS) != 9'h000 || (LEFT_KEY | LEFT_PRESS) != 4'h0) bad++;
        end
        chk("idle_outputs", bad, 0);

        // Steady left press and release
        wait_tick(1);
        LEFT_BTN_N = 4'b1011;
        wait_tick(2);
        chk("left2_early", LEFT_KEY, 4'h0);
        wait_tick(1);
        chk("left2_rise", LEFT_KEY, 4'b0100);
        chk("left2_pulse", LEFT_PRESS, 4'b0100);
        @(posedge CLK);
        #1;
        chk("left2_pulse_end", LEFT_PRESS, 4'h0);
        chk("left2_held", LEFT_KEY, 4'b0100);
        wait_tick(1);
        LEFT_BTN_N = 4'hF;
        clr_mon();
        wait_tick(2);
        chk("left2_rel_early", LEFT_KEY, 4'b0100);
        wait_tick(1);
        chk("left2_fall", LEFT_KEY, 4'h0);
        @(negedge CLK);
        #1;
        chk("left2_no_rel_pulse", lp_total, 0);

        // Bounce on left button 0: a sample equal to the stable state restarts the count
        LEFT_BTN_N = 4'b1110;
        wait_tick(1);
        LEFT_BTN_N = 4'hF;
        wait_tick(1);
        LEFT_BTN_N = 4'b1110;
        wait_tick(2);
        chk("bounce_early", LEFT_KEY, 4'h0);
        wait_tick(1);
        chk("bounce_rise", LEFT_KEY, 4'h1);
        chk("bounce_pulse", LEFT_PRESS, 4'h1);
        LEFT_BTN_N = 4'hF;
        wait_tick(3);
        chk("bounce_release", LEFT_KEY, 4'h0);
        @(negedge CLK);
        #1;

        // Directed vector table
        for (int v = 0; v < 10; v++) begin
            LEFT_BTN_N = vecs[v].left_n;
            pads       = vecs[v].pads;
            clr_mon();
            wait_tick(vecs[v].ticks);
            chk($sformatf("vec%0d_key", v), KEY, vecs[v].key);
            chk($sformatf("vec%0d_lkey", v), LEFT_KEY, vecs[v].lkey);
            @(negedge CLK);
            #1;
            chk($sformatf("vec%0d_kp_mask", v), kp_seen, vecs[v].kpm);
            chk($sformatf("vec%0d_kp_count", v), kp_total, vecs[v].kpn);
            chk($sformatf("vec%0d_lp_mask", v), lp_seen, vecs[v].lpm);
            chk($sformatf("vec%0d_lp_count", v), lp_total, vecs[v].lpn);
        end

        // Asynchronous reset while pad 5 is held
        pads = 9'h020;
        wait_tick(9);
        chk("pre_rst_key5", KEY, 9'h020);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("async_rst_key", KEY, 9'h000);
        chk("async_rst_col", COL_OUT, 3'b110);
        chk("async_rst_left", {LEFT_KEY, LEFT_PRESS, KEY_PRESS}, 17'h0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        wait_tick(7);
        chk("rst_redetect_early", KEY, 9'h000);
        wait_tick(1);
        chk("rst_redetect_key", KEY, 9'h020);
        chk("rst_redetect_pulse", KEY_PRESS, 9'h020);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
